// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: PC register, ROM request generation and a prefetch FIFO
// that hands words to ID with first-word-fall-through. Branches keep one delay slot;
// an exception flush discards every queued word.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        rom_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    input  logic        id_ready_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW + 1)'(2);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_TWO  = AW'(2);

    typedef enum logic {StNormal, StDslotWait} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     tgt_q, tgt_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            run_q;
    logic            mem_we;

    logic [31:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_inst [DEPTH];

    logic            wr;
    logic            rd;
    logic            branch_take;

    assign wr          = rom_ce_o & rom_ready_i;
    assign rd          = id_valid_o & id_ready_i;
    // Branches inside the delay-slot wait are illegal and therefore ignored.
    assign branch_take = rd & branch_flag_i & (state_q == StNormal);
    assign rom_addr_o  = pc_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StNormal;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state for the FSM and the fetch/queue datapath
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_we   = 1'b0;

        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = flush_pc_i;
            state_d  = StNormal;
        end else if (branch_take) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (count_q >= CNT_TWO) begin
                // Delay slot already queued right behind the head; drop everything after it.
                count_d  = CNT_ONE;
                wr_ptr_d = rd_ptr_q + PTR_TWO;
                pc_d     = branch_target_i;
            end else if (wr) begin
                // The word arriving now is the delay slot.
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = CNT_ONE;
                pc_d     = branch_target_i;
            end else begin
                // Delay slot not fetched yet: keep fetching at pc, redirect afterwards.
                count_d  = '0;
                tgt_d    = branch_target_i;
                state_d  = StDslotWait;
            end
        end else begin
            if (wr) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (state_q == StDslotWait) begin
                    pc_d    = tgt_q;
                    state_d = StNormal;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            if (rd) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({wr, rd})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FSM outputs: ROM request and FWFT head presentation
    always_comb begin
        rom_ce_o   = run_q & (count_q < FULL_CNT);
        id_valid_o = (count_q != '0);
        id_pc_o    = id_valid_o ? mem_pc[rd_ptr_q]   : 32'h0;
        id_inst_o  = id_valid_o ? mem_inst[rd_ptr_q] : 32'h0;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            tgt_q    <= 32'h0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            run_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            run_q    <= 1'b1;
        end
    end

    // Queue storage; stale contents are harmless since count gates visibility
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_pc[wr_ptr_q]   <= pc_q;
            mem_inst[wr_ptr_q] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: a queue-based reference model tracks the
// expected FIFO contents and fetch PC; a monitor compares the DUT every cycle.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH       = 4;
    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          N_CYCLES    = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        rom_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_inst = rom_fn(rom_addr);

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_inst_i      (rom_inst),
        .rom_ready_i     (rom_ready),
        .id_valid_o      (id_valid),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_ready_i      (id_ready),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .flush_i         (flush),
        .flush_pc_i      (flush_pc)
    );

    // Reference model state: queue of expected entries plus fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc    = TB_RESET_PC;
    logic [31:0] m_tgt   = 32'h0;
    bit          m_run   = 1'b0;
    bit          m_dslot = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Model update on each rising edge from the inputs driven half a cycle earlier.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                m_pc    = TB_RESET_PC;
                m_run   = 1'b0;
                m_dslot = 1'b0;
            end else begin
                bit   m_wr;
                bit   m_rd;
                ent_t e;
                m_wr  = m_run && (exp_q.size() < DEPTH) && rom_ready;
                m_rd  = (exp_q.size() != 0) && id_ready;
                m_run = 1'b1;
                if (flush) begin
                    exp_q.delete();
                    m_pc    = flush_pc;
                    m_dslot = 1'b0;
                end else if (m_rd && branch_flag && !m_dslot) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() >= 1) begin
                        e = exp_q[0];
                        exp_q.delete();
                        exp_q.push_back(e);
                        m_pc = branch_target;
                    end else if (m_wr) begin
                        exp_q.push_back('{m_pc, rom_fn(m_pc)});
                        m_pc = branch_target;
                    end else begin
                        m_tgt   = branch_target;
                        m_dslot = 1'b1;
                    end
                end else begin
                    if (m_rd) void'(exp_q.pop_front());
                    if (m_wr) begin
                        exp_q.push_back('{m_pc, rom_fn(m_pc)});
                        if (m_dslot) begin
                            m_pc    = m_tgt;
                            m_dslot = 1'b0;
                        end else begin
                            m_pc = m_pc + 32'd4;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            check("rom_ce", {31'b0, rom_ce},
                  {31'b0, m_run && (exp_q.size() < DEPTH)});
            check("rom_addr", rom_addr, m_pc);
            check("id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("id_pc", id_pc, exp_q[0].pc);
                check("id_inst", id_inst, exp_q[0].inst);
            end else begin
                check("id_pc_idle", id_pc, 32'h0);
                check("id_inst_idle", id_inst, 32'h0);
            end
        end
    end

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0;
        return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // Stimulus: reset, fill with ID stalled, then randomized traffic.
    initial begin
        rst           = 1'b1;
        rom_ready     = 1'b1;
        id_ready      = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        id_ready = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 149) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            flush_pc      = rand_target();
            branch_flag   = ($urandom_range(0, 3) == 0);
            branch_target = rand_target();
            id_ready      = ($urandom_range(0, 9) < 7);
            rom_ready     = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst         = 1'b0;
        flush       = 1'b0;
        branch_flag = 1'b0;
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
